// File: rtl/mem_copy_sequencer_pkg.sv
// Shared types for the block-copy sequencer: FSM encoding, the order of
// the completion-marker symbols and the default marker constants.
package mem_copy_sequencer_pkg;

    localparam int MEM_BITS = 2;

    localparam logic [MEM_BITS-1:0] ALL_ONES  = '1;
    localparam logic [MEM_BITS-1:0] ALL_ZEROS = '0;

    typedef enum logic [2:0] {
        IDLE,
        COPY,
        DRAIN,
        M1A,
        M0A,
        M1B,
        M0B,
        FIN
    } state_t;

    // Marker symbols alternate ones/zeros; ones are shown in M1A and M1B.
    function automatic logic mark_is_ones(input state_t s);
        return (s == M1A) || (s == M1B);
    endfunction

    function automatic state_t mark_next(input state_t s);
        state_t n;
        n = FIN;
        unique case (s)
            M1A:     n = M0A;
            M0A:     n = M1B;
            M1B:     n = M0B;
            default: n = FIN;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_copy_sequencer.sv
// Copies NUM_WORDS words from a source memory to a destination memory,
// then plays the 1/0/1/0 completion marker on data_out for the detector.
module mem_copy_sequencer
    import mem_copy_sequencer_pkg::*;
#(
    parameter int no_of_mem_bits = MEM_BITS,
    parameter int addr_bits      = 4,
    parameter int NUM_WORDS      = 16,
    parameter int MARK_HOLD      = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic [addr_bits-1:0]      src_rd_addr,
    input  logic [no_of_mem_bits-1:0] src_rd_data,
    output logic                      dst_wr_en,
    output logic [addr_bits-1:0]      dst_wr_addr,
    output logic [no_of_mem_bits-1:0] dst_wr_data,
    output logic [no_of_mem_bits-1:0] data_out,
    output logic                      det_clr,
    output logic                      busy,
    output logic                      done
);

    localparam int CW = addr_bits + 1;
    localparam int HW = (MARK_HOLD > 1) ? $clog2(MARK_HOLD) : 1;

    state_t         r_state;
    state_t         w_next;
    logic [CW-1:0]  r_cnt;
    logic [HW-1:0]  r_hold;
    logic           w_hold_end;
    logic           w_mark;

    assign w_hold_end = (r_hold == HW'(MARK_HOLD - 1));
    assign w_mark     = r_state inside {M1A, M0A, M1B, M0B};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:  if (start) w_next = COPY;
            COPY:  if (r_cnt == CW'(NUM_WORDS)) w_next = DRAIN;
            DRAIN: w_next = M1A;
            M1A, M0A, M1B, M0B: begin
                if (w_hold_end) w_next = mark_next(r_state);
            end
            FIN:   w_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            src_rd_addr <= '0;
            dst_wr_en   <= 1'b0;
            dst_wr_addr <= '0;
            dst_wr_data <= '0;
            data_out    <= '0;
            det_clr     <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            r_cnt       <= '0;
            r_hold      <= '0;
        end else begin
            dst_wr_en <= (r_state == COPY);
            busy      <= w_next inside {COPY, DRAIN, M1A, M0A, M1B, M0B};
            done      <= (w_next == FIN);

            if (r_state == COPY) begin
                dst_wr_addr <= src_rd_addr;
                dst_wr_data <= src_rd_data;
                data_out    <= src_rd_data;
            end else begin
                data_out <= {no_of_mem_bits{mark_is_ones(w_next)}};
            end

            // Clear stays low after the marker so transfer_done is held.
            if (w_next == COPY) begin
                det_clr <= 1'b1;
            end else if (w_next == M1A) begin
                det_clr <= 1'b0;
            end

            if (w_mark) begin
                r_hold <= w_hold_end ? '0 : r_hold + HW'(1);
            end else begin
                r_hold <= '0;
            end

            if (r_state == IDLE && start) begin
                r_cnt       <= CW'(1);
                src_rd_addr <= '0;
            end else if (r_state == COPY && w_next == COPY) begin
                r_cnt       <= r_cnt + CW'(1);
                src_rd_addr <= src_rd_addr + addr_bits'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_copy_sequencer.sv
// Directed bench for mem_copy_sequencer with a behavioural detector model.
module tb_mem_copy_sequencer;

    logic clk;
    logic rst_n;
    logic st [3];

    logic [3:0] a_ra, b_ra, c_ra, a_wa, b_wa, c_wa;
    logic [1:0] a_rd, b_rd, c_rd, a_wd, b_wd, c_wd, a_do, b_do, c_do;
    logic       a_en, b_en, c_en, a_clr, b_clr, c_clr;
    logic       a_bsy, b_bsy, c_bsy, a_dn, b_dn, c_dn;

    logic [1:0] src [3][16];
    logic [1:0] dst_c [16];
    int         wcnt [3];
    int         dcnt [3];
    int         n_vec;
    int         n_bad;

    logic [3:0] o_ra, o_wa;
    logic [1:0] o_wd, o_do;
    logic       o_en, o_clr, o_bsy, o_dn;

    logic       td;
    int         ph;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign a_rd = src[0][a_ra];
    assign b_rd = src[1][b_ra];
    assign c_rd = src[2][c_ra];

    mem_copy_sequencer #(.no_of_mem_bits(2), .addr_bits(4),
                         .NUM_WORDS(4), .MARK_HOLD(1)) u_a (
        .clk(clk), .rst_n(rst_n), .start(st[0]),
        .src_rd_addr(a_ra), .src_rd_data(a_rd),
        .dst_wr_en(a_en), .dst_wr_addr(a_wa), .dst_wr_data(a_wd),
        .data_out(a_do), .det_clr(a_clr), .busy(a_bsy), .done(a_dn));

    mem_copy_sequencer #(.no_of_mem_bits(2), .addr_bits(4),
                         .NUM_WORDS(4), .MARK_HOLD(3)) u_b (
        .clk(clk), .rst_n(rst_n), .start(st[1]),
        .src_rd_addr(b_ra), .src_rd_data(b_rd),
        .dst_wr_en(b_en), .dst_wr_addr(b_wa), .dst_wr_data(b_wd),
        .data_out(b_do), .det_clr(b_clr), .busy(b_bsy), .done(b_dn));

    mem_copy_sequencer #(.no_of_mem_bits(2), .addr_bits(4),
                         .NUM_WORDS(16), .MARK_HOLD(1)) u_c (
        .clk(clk), .rst_n(rst_n), .start(st[2]),
        .src_rd_addr(c_ra), .src_rd_data(c_rd),
        .dst_wr_en(c_en), .dst_wr_addr(c_wa), .dst_wr_data(c_wd),
        .data_out(c_do), .det_clr(c_clr), .busy(c_bsy), .done(c_dn));

    always @(posedge clk) begin
        if (a_en) wcnt[0] <= wcnt[0] + 1;
        if (b_en) wcnt[1] <= wcnt[1] + 1;
        if (c_en) wcnt[2] <= wcnt[2] + 1;
        if (a_dn) dcnt[0] <= dcnt[0] + 1;
        if (b_dn) dcnt[1] <= dcnt[1] + 1;
        if (c_dn) dcnt[2] <= dcnt[2] + 1;
        if (c_en) dst_c[c_wa] <= c_wd;
    end

    // Detector model on instance A: 1,0,1,0 symbol sequence while enabled.
    always @(posedge clk) begin
        if (!rst_n || a_clr) begin
            td <= 1'b0;
            ph <= 0;
        end else if (!td) begin
            case (ph)
                0: if (a_do == 2'b11) ph <= 1;
                1: if (a_do == 2'b00) ph <= 2;
                2: if (a_do == 2'b11) ph <= 3;
                default: if (a_do == 2'b00) td <= 1'b1;
            endcase
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input int c,
                        input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s cyc %0d: got %0d want %0d", tag, c, obs, exp);
        end
    endtask

    task automatic snap(input int id);
        case (id)
            0: begin
                o_ra = a_ra; o_wa = a_wa; o_wd = a_wd; o_do = a_do;
                o_en = a_en; o_clr = a_clr; o_bsy = a_bsy; o_dn = a_dn;
            end
            1: begin
                o_ra = b_ra; o_wa = b_wa; o_wd = b_wd; o_do = b_do;
                o_en = b_en; o_clr = b_clr; o_bsy = b_bsy; o_dn = b_dn;
            end
            default: begin
                o_ra = c_ra; o_wa = c_wa; o_wd = c_wd; o_do = c_do;
                o_en = c_en; o_clr = c_clr; o_bsy = c_bsy; o_dn = c_dn;
            end
        endcase
    endtask

    task automatic chk_reset(input int id, input int c);
        snap(id);
        chk1($sformatf("rst%0d.ra", id), c, 32'(o_ra), 0);
        chk1($sformatf("rst%0d.en", id), c, 32'(o_en), 0);
        chk1($sformatf("rst%0d.wa", id), c, 32'(o_wa), 0);
        chk1($sformatf("rst%0d.wd", id), c, 32'(o_wd), 0);
        chk1($sformatf("rst%0d.do", id), c, 32'(o_do), 0);
        chk1($sformatf("rst%0d.clr", id), c, 32'(o_clr), 1);
        chk1($sformatf("rst%0d.busy", id), c, 32'(o_bsy), 0);
        chk1($sformatf("rst%0d.done", id), c, 32'(o_dn), 0);
    endtask

    task automatic chk_cycle(input int id, input int c,
                             input int n, input int h);
        logic       e_en;
        logic [1:0] e_do;
        e_en = (c >= 2) && (c <= n + 1);
        if (e_en) e_do = src[id][c-2];
        else if (c >= n + 2 && c <= n + 1 + 4*h)
            e_do = (((c - n - 2) / h) % 2 == 0) ? 2'b11 : 2'b00;
        else e_do = 2'b00;
        snap(id);
        chk1($sformatf("i%0d.en", id), c, 32'(o_en), 32'(e_en));
        chk1($sformatf("i%0d.do", id), c, 32'(o_do), 32'(e_do));
        chk1($sformatf("i%0d.clr", id), c, 32'(o_clr),
             32'(c <= n + 1));
        chk1($sformatf("i%0d.busy", id), c, 32'(o_bsy),
             32'(c >= 1 && c <= n + 1 + 4*h));
        chk1($sformatf("i%0d.done", id), c, 32'(o_dn),
             32'(c == n + 2 + 4*h));
        if (c <= n) chk1($sformatf("i%0d.ra", id), c, 32'(o_ra), c - 1);
        if (e_en) begin
            chk1($sformatf("i%0d.wa", id), c, 32'(o_wa), c - 2);
            chk1($sformatf("i%0d.wd", id), c, 32'(o_wd),
                 32'(src[id][c-2]));
        end
    endtask

    task automatic run(input int id, input int n, input int h,
                       input int ncyc, input logic prev_td,
                       input bit again);
        st[id] = 1'b1;
        step;
        st[id] = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            chk_cycle(id, c, n, h);
            if (id == 0)
                chk1("td", c, 32'(td),
                     32'((c == 1) ? prev_td : (c >= n + 3 + 3*h)));
            st[id] = again && (c == 4 || c == 8);
            step;
            st[id] = 1'b0;
        end
    endtask

    initial begin
        int w0;
        int d0;
        logic [1:0] tc [16];
        n_vec = 0;
        n_bad = 0;
        for (int i = 0; i < 3; i++) begin
            st[i] = 1'b0;
            wcnt[i] = 0;
            dcnt[i] = 0;
            for (int j = 0; j < 16; j++) src[i][j] = 2'b00;
        end
        src[0][0] = 2'd3; src[0][1] = 2'd0;
        src[0][2] = 2'd3; src[0][3] = 2'd0;
        src[1][0] = 2'd1; src[1][1] = 2'd2;
        src[1][2] = 2'd3; src[1][3] = 2'd1;
        tc = '{2'd2, 2'd1, 2'd3, 2'd0, 2'd3, 2'd3, 2'd1, 2'd2,
               2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0, 2'd1, 2'd2};
        for (int j = 0; j < 16; j++) src[2][j] = tc[j];

        rst_n = 1'b0;
        repeat (3) step;
        chk_reset(0, 0);
        chk_reset(1, 0);
        chk_reset(2, 0);
        rst_n = 1'b1;
        repeat (2) step;

        // Basic copy of 3,0,3,0 then marker, done and held transfer_done.
        run(0, 4, 1, 12, 1'b0, 1'b0);
        chk1("a.writes", 12, 32'(wcnt[0]), 4);

        // Starts during COPY and the marker are ignored; restart clears td.
        w0 = wcnt[0];
        d0 = dcnt[0];
        run(0, 4, 1, 14, 1'b1, 1'b1);
        chk1("a.writes2", 14, 32'(wcnt[0] - w0), 4);
        chk1("a.dones2", 14, 32'(dcnt[0] - d0), 1);

        // Reset mid-copy abandons the run.
        st[0] = 1'b1;
        step;
        st[0] = 1'b0;
        repeat (2) step;
        rst_n = 1'b0;
        step;
        chk_reset(0, 4);
        chk1("a.td_rst", 4, 32'(td), 0);
        rst_n = 1'b1;
        d0 = dcnt[0];
        repeat (12) step;
        chk1("a.nodone", 16, 32'(dcnt[0] - d0), 0);
        chk1("a.idle_busy", 16, 32'(a_bsy), 0);
        run(0, 4, 1, 12, 1'b0, 1'b0);

        // Longer marker hold.
        run(1, 4, 3, 20, 1'b0, 1'b0);
        chk1("b.dones", 20, 32'(dcnt[1]), 1);

        // Full address space, no wrap.
        run(2, 16, 1, 24, 1'b0, 1'b0);
        chk1("c.writes", 24, 32'(wcnt[2]), 16);
        for (int j = 0; j < 16; j++)
            chk1($sformatf("c.dst%0d", j), 24, 32'(dst_c[j]), 32'(tc[j]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
